// File: rtl/cfi_log_queue.sv
// CFI commit-log queue: collects control-flow records from the commit ports and
// presents them in order to the CFI monitor with occupancy, stall and overflow status.
package cfi_log_pkg;
  typedef struct packed {
    logic [31:0] addr_pc;
    logic [31:0] addr_target;
  } cfi_commit_log_t;

  localparam int CfiLogWidth = $bits(cfi_commit_log_t);
endpackage

module cfi_log_queue #(
  parameter int NrCommitPorts = 2,
  parameter int Depth         = 8
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic [NrCommitPorts-1:0]                      cfi_i,
  input  logic [NrCommitPorts*cfi_log_pkg::CfiLogWidth-1:0] log_i,
  input  logic [NrCommitPorts-1:0]                      commit_ack_i,
  input  logic                                          flush_i,
  output logic [cfi_log_pkg::CfiLogWidth-1:0]           log_o,
  output logic                                          valid_o,
  input  logic                                          ready_i,
  output logic                                          stall_o,
  output logic [$clog2(Depth):0]                        usage_o,
  output logic                                          overflow_o
);
  localparam int AW = $clog2(Depth);
  localparam int CW = AW + 1;
  localparam int LW = cfi_log_pkg::CfiLogWidth;

  logic [LW-1:0]            mem [Depth];
  logic [AW-1:0]            head_reg;
  logic [AW-1:0]            tail_reg;
  logic [CW-1:0]            usage_reg;
  logic [CW-1:0]            usage_next;
  logic                     overflow_reg;

  logic [NrCommitPorts-1:0] push_req;
  logic [NrCommitPorts-1:0] wr_en;
  logic [AW-1:0]            wr_idx [NrCommitPorts];
  logic [CW-1:0]            space;
  logic [CW-1:0]            acc_cnt;
  logic                     drop;
  logic                     pop;

  assign valid_o    = (usage_reg != '0);
  assign usage_o    = usage_reg;
  assign overflow_o = overflow_reg;
  assign log_o      = valid_o ? mem[head_reg] : '0;
  assign stall_o    = ((CW'(Depth) - usage_reg) < CW'(NrCommitPorts));
  assign pop        = valid_o & ready_i;

  // Requesters are granted in ascending port order, so once space runs out
  // the remaining (higher) ports are the ones dropped.
  always_comb begin
    push_req = cfi_i & commit_ack_i;
    space    = CW'(Depth) - usage_reg + {{(CW-1){1'b0}}, pop};
    acc_cnt  = '0;
    drop     = 1'b0;
    wr_en    = '0;
    for (int p = 0; p < NrCommitPorts; p++) begin
      wr_idx[p] = tail_reg + acc_cnt[AW-1:0];
      if (push_req[p]) begin
        if (acc_cnt < space) begin
          wr_en[p] = 1'b1;
          acc_cnt  = acc_cnt + 1'b1;
        end else begin
          drop = 1'b1;
        end
      end
    end
    usage_next = usage_reg + acc_cnt - {{(CW-1){1'b0}}, pop};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      usage_reg    <= '0;
      overflow_reg <= 1'b0;
    end else if (flush_i) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      usage_reg <= '0;
    end else begin
      head_reg  <= head_reg + {{(AW-1){1'b0}}, pop};
      tail_reg  <= tail_reg + acc_cnt[AW-1:0];
      usage_reg <= usage_next;
      if (drop) overflow_reg <= 1'b1;
    end
  end

  // Storage is never cleared; only writes of accepted records land.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NrCommitPorts; p++) begin
      if (!rst_i && !flush_i && wr_en[p]) mem[wr_idx[p]] <= log_i[p*LW +: LW];
    end
  end
endmodule

// File: tb/tb_cfi_log_queue.sv
// Directed testbench for cfi_log_queue with hand-computed expected values.
module tb_cfi_log_queue;
  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   cfi;
  logic [127:0] log_in;
  logic [1:0]   ack;
  logic         flush;
  logic [63:0]  log_out;
  logic         valid;
  logic         ready;
  logic         stall;
  logic [3:0]   usage;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cfi_log_queue #(.NrCommitPorts(2), .Depth(8)) dut (
    .clk_i(clk), .rst_i(rst), .cfi_i(cfi), .log_i(log_in), .commit_ack_i(ack),
    .flush_i(flush), .log_o(log_out), .valid_o(valid), .ready_i(ready),
    .stall_o(stall), .usage_o(usage), .overflow_o(overflow)
  );

  function automatic logic [63:0] mk(input logic [31:0] pc);
    return {pc, pc ^ 32'hFFFF_0000};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of stimulus; en selects ports that are flagged and acknowledged.
  task automatic cycle(input logic [1:0] en, input logic [31:0] pc0, input logic [31:0] pc1,
                       input logic rdy, input logic fl, input logic rs);
    cfi    = en;
    ack    = en;
    log_in = {mk(pc1), mk(pc0)};
    ready  = rdy;
    flush  = fl;
    rst    = rs;
    tick();
    cfi   = '0;
    ack   = '0;
    ready = 1'b0;
    flush = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".usage"}, 64'(usage), 64'd0);
    check({tag, ".valid"}, 64'(valid), 64'd0);
    check({tag, ".stall"}, 64'(stall), 64'd0);
    check({tag, ".overflow"}, 64'(overflow), 64'd0);
    check({tag, ".log"}, log_out, 64'd0);
  endtask

  initial begin
    rst = 1'b1; cfi = '0; ack = '0; log_in = '0; flush = 1'b0; ready = 1'b0;
    tick();
    cycle(2'b00, 0, 0, 1'b0, 1'b0, 1'b1);
    check_zero("reset");

    // Single push held while the monitor is not ready
    cycle(2'b01, 32'h8000_0010, 0, 1'b0, 1'b0, 1'b0);
    check("hold.valid", 64'(valid), 64'd1);
    check("hold.usage", 64'(usage), 64'd1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold.log%0d", i), log_out, mk(32'h8000_0010));
      cycle(2'b00, 0, 0, 1'b0, 1'b0, 1'b0);
    end
    cycle(2'b00, 0, 0, 1'b1, 1'b0, 1'b0);
    check("hold.popped_usage", 64'(usage), 64'd0);
    check("hold.popped_log", log_out, 64'd0);

    // Dual push, ascending order
    cycle(2'b11, 32'h100, 32'h104, 1'b1, 1'b0, 1'b0);
    check("dual.usage2", 64'(usage), 64'd2);
    check("dual.log0", log_out, mk(32'h100));
    cycle(2'b00, 0, 0, 1'b1, 1'b0, 1'b0);
    check("dual.usage1", 64'(usage), 64'd1);
    check("dual.log1", log_out, mk(32'h104));
    cycle(2'b00, 0, 0, 1'b1, 1'b0, 1'b0);
    check("dual.usage0", 64'(usage), 64'd0);
    check("dual.valid0", 64'(valid), 64'd0);

    // Fill to 7, then a dual push drops port 1
    cycle(2'b00, 0, 0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      cycle(2'b01, 32'h200 + 32'(4*i), 0, 1'b0, 1'b0, 1'b0);
      check($sformatf("fill.stall%0d", i + 1), 64'(stall), (i + 1 >= 7) ? 64'd1 : 64'd0);
    end
    check("fill.overflow_pre", 64'(overflow), 64'd0);
    cycle(2'b11, 32'h300, 32'h304, 1'b0, 1'b0, 1'b0);
    check("ovf.usage", 64'(usage), 64'd8);
    check("ovf.flag", 64'(overflow), 64'd1);
    check("ovf.stall", 64'(stall), 64'd1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ovf.drain%0d", i), log_out,
            (i < 7) ? mk(32'h200 + 32'(4*i)) : mk(32'h300));
      cycle(2'b00, 0, 0, 1'b1, 1'b0, 1'b0);
    end
    check("ovf.empty", 64'(usage), 64'd0);
    check("ovf.sticky", 64'(overflow), 64'd1);

    // Full queue: push with simultaneous pop, tail wraps to slot 0
    cycle(2'b00, 0, 0, 1'b0, 1'b0, 1'b1);
    check("wrap.ovf_cleared", 64'(overflow), 64'd0);
    for (int i = 0; i < 8; i++) cycle(2'b01, 32'h400 + 32'(4*i), 0, 1'b0, 1'b0, 1'b0);
    check("wrap.full", 64'(usage), 64'd8);
    cycle(2'b01, 32'h500, 0, 1'b1, 1'b0, 1'b0);
    check("wrap.usage", 64'(usage), 64'd8);
    check("wrap.overflow", 64'(overflow), 64'd0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("wrap.drain%0d", i), log_out,
            (i < 7) ? mk(32'h404 + 32'(4*i)) : mk(32'h500));
      cycle(2'b00, 0, 0, 1'b1, 1'b0, 1'b0);
    end

    // Flush with a simultaneous push, then reset mid-operation
    for (int i = 0; i < 5; i++) cycle(2'b01, 32'h580 + 32'(4*i), 0, 1'b0, 1'b0, 1'b0);
    check("flush.pre", 64'(usage), 64'd5);
    cycle(2'b01, 32'h5F0, 0, 1'b1, 1'b1, 1'b0);
    check("flush.usage", 64'(usage), 64'd0);
    check("flush.valid", 64'(valid), 64'd0);
    check("flush.log", log_out, 64'd0);
    cycle(2'b01, 32'h600, 0, 1'b0, 1'b0, 1'b0);
    check("flush.restart", log_out, mk(32'h600));
    cycle(2'b11, 32'h604, 32'h608, 1'b0, 1'b0, 1'b0);
    check("rst.pre", 64'(usage), 64'd3);
    cycle(2'b11, 32'h700, 32'h704, 1'b1, 1'b1, 1'b1);
    check_zero("rst.mid");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cfi_log_queue.md
CFI_LOG_QUEUE -- requirements
Module: cfi_log_queue

Interface
REQ-001 Parameter NrCommitPorts, default 2: number of commit ports scanned per cycle.
REQ-002 Parameter Depth, default 8: queue entries; power of two, >= 2*NrCommitPorts.
REQ-003 Clocking SHALL be one clock with a synchronous, active-high reset.
REQ-004 clk_i  in  1  clock; all state updates on its rising edge.
REQ-005 rst_i  in  1  synchronous active-high reset.
REQ-006 cfi_i  in  NrCommitPorts  per-port flag: commit entry is a valid control-flow instruction.
REQ-007 log_i  in  NrCommitPorts x cfi_commit_log_t  per-port CFI log record.
REQ-008 commit_ack_i  in  NrCommitPorts  per-port flag: the entry retires this cycle.
REQ-009 flush_i  in  1  drop all queued records.
REQ-010 log_o  out  cfi_commit_log_t  head record toward the CFI monitor.
REQ-011 valid_o  out  1  head record present.
REQ-012 ready_i  in  1  monitor accepts the head record.
REQ-013 stall_o  out  1  commit stage must not retire CFI instructions next cycle.
REQ-014 usage_o  out  $clog2(Depth)+1  current occupancy.
REQ-015 overflow_o  out  1  sticky flag: a record was dropped.

Function
REQ-016 Push condition per port p: cfi_i[p] && commit_ack_i[p].
REQ-017 All pushes in one cycle are written in ascending port order at consecutive tail slots; tail advances by the push count.
REQ-018 Pop occurs when valid_o && ready_i; head advances by 1.
REQ-019 valid_o = (usage_o != 0); log_o = entry at head, combinational from storage; log_o is zero when empty.
REQ-020 Push and pop in the same cycle are both honoured; next usage = usage + pushes - pop.
REQ-021 A push into a full queue is legal when a pop occurs in the same cycle, provided the result is <= Depth.
REQ-022 Pointers are $clog2(Depth) bits and wrap modulo Depth without a gap.
REQ-023 stall_o = 1 when Depth - usage_o < NrCommitPorts; registered-state based, combinational from usage_o; it does not depend on same-cycle pops.
REQ-024 Overflow: pushes beyond available space (Depth - usage + pop) are dropped, highest port first; overflow_o sets the next cycle and holds until reset.
REQ-025 A record accepted while valid_o && !ready_i stays stable on log_o until popped.
REQ-026 flush_i: next cycle head = tail = 0, usage = 0; pushes and pop in the flush cycle are discarded; overflow_o is unchanged.
REQ-027 Unflagged ports (cfi_i=0) or unacknowledged ports never consume slots.

Reset
REQ-028 In the cycle rst_i is sampled high: head, tail and usage_o become 0, valid_o = 0, stall_o = 0, overflow_o = 0, and log_o is zero.
REQ-029 Reset takes priority over flush_i, push and pop, including mid-operation with a non-empty queue.
REQ-030 Storage contents need not be cleared; only the pointers and flags are reset.

Verification
REQ-031 Reset, then one push on port 0 with addr_pc=0x80000010 and ready_i=0 -> next cycle valid_o=1, usage_o=1, log_o.addr_pc=0x80000010; the record is held for 5 cycles.
REQ-032 Same-cycle pushes on port 0 (pc=0x100) and port 1 (pc=0x104) with ready_i=1 -> pops return 0x100 then 0x104; usage_o goes 2,1,0.
REQ-033 Depth=8, fill to 7 with ready_i=0 -> stall_o=1 once usage_o>=7; a double push at usage 7 stores port 0 only, drops port 1, and sets overflow_o=1.
REQ-034 Usage 8 with ready_i=1 and one push -> usage stays 8, overflow_o stays 0, and the tail wraps to slot 0.
REQ-035 Usage 5, flush_i=1 with a simultaneous push -> next cycle usage_o=0 and valid_o=0; rst_i asserted with usage 3 -> all outputs 0 next cycle.
